// File: rtl/instr_fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch queue: fetch FSM state
// encoding, fetch word geometry and the default queue depth.
// -----------------------------------------------------------------------------
package fetch_pkg;

    // Fetch FSM states.
    //   IDLE : no request on the bus
    //   REQ  : request on the bus, response will be queued
    //   DROP : request on the bus, response will be thrown away (redirected)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    localparam int WORD_BYTES    = 4;
    localparam int PC_INC        = 4;
    localparam int DEFAULT_DEPTH = 4;

endpackage : fetch_pkg

// File: rtl/instr_fetch_queue_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO holding {pc, instruction} pairs between program memory and
// decode. Simultaneous push and pop are legal in every state, including full;
// a pop while empty is ignored. i_flush empties the queue at the clock edge
// and overrides any push/pop in the same cycle.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-low reset
//   i_push   in   write i_data at the tail
//   i_data   in   WIDTH-bit entry
//   i_pop    in   drop the head entry
//   i_flush  in   empty the queue
//   o_full   out  count == DEPTH
//   o_empty  out  count == 0
//   o_count  out  number of stored entries (0..DEPTH)
//   o_head   out  head entry, zero while empty
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_count;
    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Masking keeps the head at zero while empty without resetting storage.
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // NOTE: storage has no reset; its contents are only observable through
    // the count-qualified head, so clearing it would buy nothing.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule : fetch_fifo

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch side of the PC / program-memory interface. Owns the fetch address,
// issues one outstanding word read at a time over a req/ack handshake, queues
// returned words with their addresses and offers them to decode over
// valid/ready. A redirect flushes the queue and restarts fetch at the target;
// an in-flight request is completed on the bus and its data discarded.
//
// Build option: define FETCH_STATS_EN to add the saturating fetch_count and
// drop_count outputs. Core behaviour is identical either way.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-low reset
//   redirect     in   taken branch: flush and refetch
//   redirect_pc  in   new fetch target, bits [1:0] ignored
//   mem_req      out  read request (registered)
//   mem_addr     out  word-aligned read address (registered)
//   mem_ack      in   read complete, mem_rdata valid this cycle
//   mem_rdata    in   read data
//   instr_valid  out  queue head valid
//   instr        out  head instruction
//   instr_pc     out  head address
//   instr_ready  in   decode accepts the head
//   fetch_count  out  [FETCH_STATS_EN] words pushed, saturating
//   drop_count   out  [FETCH_STATS_EN] acks discarded, saturating
// -----------------------------------------------------------------------------
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = DEFAULT_DEPTH,
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]       fetch_count,
    output logic [15:0]       drop_count
`endif
);

    localparam int CNT_W      = $clog2(DEPTH) + 1;
    localparam int ALIGN_BITS = $clog2(WORD_BYTES);

    fetch_state_e              r_state;
    logic [ADDR_W-1:0]         r_fetch_addr;
    logic [ADDR_W-1:0]         r_mem_addr;
    logic                      r_mem_req;

    logic                      w_full;
    logic                      w_empty;
    logic [CNT_W-1:0]          w_count;
    logic [CNT_W-1:0]          w_count_after_push;
    logic [ADDR_W+DATA_W-1:0]  w_head;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_credit_after_push;
    logic [ADDR_W-1:0]         w_next_addr;
    logic [ADDR_W-1:0]         w_redirect_target;
    logic [ALIGN_BITS-1:0]     w_unused_pc_lsb;

    assign w_unused_pc_lsb   = redirect_pc[ALIGN_BITS-1:0];
    assign w_redirect_target = {redirect_pc[ADDR_W-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
    assign w_next_addr       = r_fetch_addr + ADDR_W'(PC_INC);

    assign w_pop  = instr_valid && instr_ready && !redirect;
    assign w_push = (r_state == REQ) && mem_ack && !redirect;

    // Credit check for chaining the next request straight after an ack: the
    // queue after this cycle's push (and possible pop) must still have room
    // for the word that request will return.
    assign w_count_after_push  = w_count + CNT_W'(1) - CNT_W'(w_pop);
    assign w_credit_after_push = (w_count_after_push < CNT_W'(DEPTH));

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_fetch_addr, mem_rdata}),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign instr_valid = !w_empty;
    assign instr_pc    = w_head[ADDR_W+DATA_W-1 -: ADDR_W];
    assign instr       = w_head[DATA_W-1:0];
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

    // mem_addr is a separate register so it can hold the abandoned address in
    // DROP while fetch_addr already points at the redirect target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_fetch_addr <= RESET_PC;
            r_mem_addr   <= RESET_PC;
            r_mem_req    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    // With nothing outstanding, credit is simply "not full".
                    if (!redirect && !w_full) begin
                        r_state    <= REQ;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= r_fetch_addr;
                    end
                end
                REQ: begin
                    if (mem_ack && !redirect) begin
                        r_fetch_addr <= w_next_addr;
                        if (w_credit_after_push) begin
                            r_mem_addr <= w_next_addr;
                        end else begin
                            r_state   <= IDLE;
                            r_mem_req <= 1'b0;
                        end
                    end else if (mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end else if (redirect) begin
                        r_state <= DROP;
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                end
            endcase
            // NOTE: the later non-blocking assignment wins, so a redirect
            // overrides any fetch_addr update made by the case above.
            if (redirect) r_fetch_addr <= w_redirect_target;
        end
    end

`ifdef FETCH_STATS_EN
    logic        w_drop_ack;
    logic [15:0] r_fetch_count;
    logic [15:0] r_drop_count;

    assign w_drop_ack = mem_ack && (((r_state == REQ) && redirect) || (r_state == DROP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_push && (r_fetch_count != 16'hFFFF))   r_fetch_count <= r_fetch_count + 16'd1;
            if (w_drop_ack && (r_drop_count != 16'hFFFF)) r_drop_count  <= r_drop_count + 16'd1;
        end
    end

    assign fetch_count = r_fetch_count;
    assign drop_count  = r_drop_count;
`endif

endmodule : instr_fetch_queue

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
// Self-checking bench for instr_fetch_queue. The bench plays program memory
// (configurable wait states) and keeps a transaction-level model of the queue:
// an ordered list of {pc, word} entries plus the next expected fetch address.
// A compare process checks the DUT against that model every cycle; directed
// scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              redirect = 1'b0;
    logic [ADDR_W-1:0] redirect_pc = '0;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready = 1'b0;
`ifdef FETCH_STATS_EN
    logic [15:0]       fetch_count;
    logic [15:0]       drop_count;
`endif

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count (fetch_count),
        .drop_count  (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Program memory image: word index in the middle byte pair, so every
    // address in the 64-word window returns a distinct, recognisable value.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {16'hC0DE, 8'(addr[7:2]), ~8'(addr[7:2])};
    endfunction

    // ---------------- memory model ----------------
    int wait_states = 0;
    int wait_cnt    = 0;
    bit inject_ack  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset || !mem_req) begin
                wait_cnt = 0;
                mem_ack  = inject_ack;
            end else if (wait_cnt >= wait_states) begin
                wait_cnt = 0;
                mem_ack  = 1'b1;
            end else begin
                wait_cnt++;
                mem_ack  = inject_ack;
            end
            mem_rdata = mem_word(mem_addr);
        end
    end

    // ---------------- reference model ----------------
    entry_t      mq[$];
    logic [31:0] delivered[$];
    logic [31:0] pushed_pc[$];
    logic [31:0] m_next_fetch = RESET_PC;
    bit          m_stale = 1'b0;
    bit          prev_pending = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          after_redirect = 1'b0;
    int          pushes = 0;
    int          drops = 0;

    // Sampled 1 time unit before each rising edge: applies that edge's effect.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!reset) begin
                mq.delete();
                delivered.delete();
                pushed_pc.delete();
                m_next_fetch   = RESET_PC;
                m_stale        = 1'b0;
                prev_pending   = 1'b0;
                after_redirect = 1'b0;
                pushes         = 0;
                drops          = 0;
            end else begin
                if (mq.size() != 0 && instr_ready && !redirect) begin
                    delivered.push_back(mq[0].pc);
                    void'(mq.pop_front());
                end
                if (mem_req && mem_ack) begin
                    if (!redirect && !m_stale) begin
                        mq.push_back('{pc: m_next_fetch, data: mem_word(m_next_fetch)});
                        pushed_pc.push_back(m_next_fetch);
                        m_next_fetch = m_next_fetch + 32'd4;
                        pushes++;
                    end else begin
                        drops++;
                    end
                    m_stale = 1'b0;
                end else if (mem_req && redirect) begin
                    m_stale = 1'b1;
                end
                if (redirect) begin
                    mq.delete();
                    m_next_fetch = redirect_pc & ~32'h3;
                end
                check("credit", mq.size() <= DEPTH, 1);
                prev_pending   = mem_req && !mem_ack;
                prev_addr      = mem_addr;
                after_redirect = redirect;
            end
        end
    end

    // Compare process: 1 time unit after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                check("instr_valid", instr_valid, mq.size() != 0);
                if (mq.size() != 0) begin
                    check("instr_pc", instr_pc, mq[0].pc);
                    check("instr", instr, mq[0].data);
                end
                if (mem_req && !m_stale) check("mem_addr", mem_addr, m_next_fetch);
                if (prev_pending) begin
                    check("req_hold", mem_req, 1);
                    check("addr_hold", mem_addr, prev_addr);
                end
                if (after_redirect) check("no_early_req", mem_req && !m_stale, 0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req_at(input logic [31:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (mem_req && mem_addr == a) ok = 1'b1;
            else step(1);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (instr_valid) ok = 1'b1;
            else step(1);
        end
    endtask

    task automatic wait_two_queued(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            if (mq.size() == 2 && mem_req) ok = 1'b1;
            else step(1);
        end
    endtask

    // Redirect during zero-wait streaming: it coincides with an ack and a pop.
    task automatic redirect_and_check(input logic [31:0] pc, input logic [31:0] exp_pc,
                                      input logic [31:0] exp_word);
        redirect    = 1'b1;
        redirect_pc = pc;
        step(1);
        redirect    = 1'b0;
        check("rd_flush_valid", instr_valid, 0);
        check("rd_flush_req", mem_req, 0);
        step(1);
        check("rd_req_valid", instr_valid, 0);
        check("rd_req", mem_req, 1);
        check("rd_req_addr", mem_addr, exp_pc);
        step(1);
        check("rd_first_valid", instr_valid, 1);
        check("rd_first_pc", instr_pc, exp_pc);
        check("rd_first_word", instr, exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    initial begin
        bit ok;

        // Reset values.
        step(1);
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_valid", instr_valid, 0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
`ifdef FETCH_STATS_EN
        check("rst_fetch_count", fetch_count, 0);
        check("rst_drop_count", drop_count, 0);
`endif

        // Zero-wait streaming, decode always ready: one word per cycle.
        instr_ready = 1'b1;
        reset       = 1'b1;
        step(10);
        check("s1_count", delivered.size(), 8);
        if (delivered.size() >= 8) begin
            check("s1_first", delivered[0], 32'h0);
            check("s1_second", delivered[1], 32'h4);
            check("s1_last", delivered[7], 32'h1C);
        end

        // Decode stalled: exactly DEPTH words fetched, then the bus goes idle.
        instr_ready = 1'b0;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(8);
        check("s2_pushes", pushed_pc.size(), 4);
        check("s2_req_off", mem_req, 0);
        check("s2_head_pc", instr_pc, 32'h0);
        check("s2_head_word", instr, 32'hC0DE_00FF);
        instr_ready = 1'b1;
        step(6);
        check("s2_resume_n", pushed_pc.size() >= 5, 1);
        if (pushed_pc.size() >= 5) check("s2_resume_pc", pushed_pc[4], 32'h10);

        // 3 wait states; redirect while the request at 0x8 is pending.
        wait_states = 3;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        wait_req_at(32'h8, ok);
        check("s3_reach_8", ok, 1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        step(1);
        redirect    = 1'b0;
        check("s3_drop_req", mem_req, 1);
        check("s3_drop_addr", mem_addr, 32'h8);
        check("s3_drop_valid", instr_valid, 0);
        wait_valid(ok);
        check("s3_valid_seen", ok, 1);
        check("s3_first_pc", instr_pc, 32'h40);
        check("s3_first_word", instr, 32'hC0DE_10EF);

        // Zero-wait streaming; redirects coinciding with ack and pop,
        // unaligned target, and address wrap.
        wait_states = 0;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        step(6);
        redirect_and_check(32'h80, 32'h80, 32'hC0DE_20DF);
        redirect_and_check(32'h13, 32'h10, 32'hC0DE_04FB);
        redirect_and_check(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hC0DE_3FC0);
        step(1);
        check("wrap_pc", instr_pc, 32'h0);
        check("wrap_word", instr, 32'hC0DE_00FF);
`ifdef FETCH_STATS_EN
        check("stat_fetch", fetch_count, pushes);
        check("stat_drop", drop_count, drops);
        check("stat_drop_lit", drop_count, 3);
`endif

        // Reset asserted asynchronously with 2 entries queued and a request pending.
        wait_states = 3;
        instr_ready = 1'b0;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        wait_two_queued(ok);
        check("s6_two_queued", ok, 1);
        #2;
        reset = 1'b0;
        #1;
        check("s6_async_valid", instr_valid, 0);
        check("s6_async_req", mem_req, 0);
        check("s6_async_pc", instr_pc, 32'h0);
        check("s6_async_addr", mem_addr, 32'h0);
`ifdef FETCH_STATS_EN
        check("s6_fetch_count", fetch_count, 0);
`endif
        // Stray ack right after release, while idle: must be ignored.
        step(1);
        reset      = 1'b1;
        inject_ack = 1'b1;
        step(1);
        inject_ack = 1'b0;
        check("s6_late_ack_valid", instr_valid, 0);
        step(2);
        check("s6_late_ack_empty", instr_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_instr_fetch_queue
